// File: rtl/seven_segment_decoder.sv
// Passive receiver for the multiplexed four-digit seven-segment bus: filters
// unstable/blanked patterns, decodes each digit to BCD and publishes whole frames.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 2000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        Clk_100M,
  input  logic        Reset_n,
  input  logic [3:0]  SegmentDrivers,
  input  logic [7:0]  SevenSegment,
  output logic [15:0] Digits,
  output logic [3:0]  Dots,
  output logic        Frame_Valid,
  output logic        Pattern_Error,
  output logic        Select_Error,
  output logic        Display_Dead
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int DW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_FIRE = SW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DEAD_MAX    = DW'(TIMEOUT);
  // Synchronizers reset to the idle bus level so release never looks like a select clash.
  localparam logic [11:0] BUS_IDLE = ACTIVE_LOW ? 12'hFFF : 12'h000;

  logic [11:0]   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [15:0]   shadow_digits_q, shadow_digits_d, digits_q, digits_d;
  logic [3:0]    shadow_dots_q, shadow_dots_d, dots_q, dots_d;
  logic [3:0]    seen_q, seen_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic          cap_q, cap_d, dead_q, dead_d;
  logic          frame_valid_q, frame_valid_d;
  logic          pattern_err_q, pattern_err_d, select_err_q, select_err_d;

  logic [11:0] sample;
  logic [3:0]  drv;
  logic [6:0]  seg;
  logic [4:0]  dec;
  logic        changed, stable_evt, one_drv, live, capture;

  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h3F:   decode_seg = {1'b1, 4'd0};
      7'h06:   decode_seg = {1'b1, 4'd1};
      7'h5B:   decode_seg = {1'b1, 4'd2};
      7'h4F:   decode_seg = {1'b1, 4'd3};
      7'h66:   decode_seg = {1'b1, 4'd4};
      7'h6D:   decode_seg = {1'b1, 4'd5};
      7'h7D:   decode_seg = {1'b1, 4'd6};
      7'h07:   decode_seg = {1'b1, 4'd7};
      7'h7F:   decode_seg = {1'b1, 4'd8};
      7'h6F:   decode_seg = {1'b1, 4'd9};
      default: decode_seg = 5'b0_0000;
    endcase
  endfunction

  assign sample = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign drv    = sample[11:8];
  assign seg    = sample[6:0];

  always_comb begin
    sync1_d = {SegmentDrivers, SevenSegment};
    sync2_d = sync1_q;
    prev_d  = sample;

    changed = (sample != prev_q);
    if (changed)                  cnt_d = '0;
    else if (cnt_q == STABLE_MAX) cnt_d = cnt_q;
    else                          cnt_d = cnt_q + SW'(1);
    // Saturation keeps this true for exactly one cycle per stable window.
    stable_evt = !changed && (cnt_d == STABLE_FIRE);

    dec     = decode_seg(seg);
    one_drv = $onehot(drv);
    live    = stable_evt && (drv != 4'h0) && (seg != 7'h00);
    capture = live && one_drv && dec[4];
    pattern_err_d = live && one_drv && !dec[4];
    select_err_d  = live && !one_drv;

    shadow_digits_d = shadow_digits_q;
    shadow_dots_d   = shadow_dots_q;
    for (int n = 0; n < 4; n++) begin
      if (capture && drv[n]) begin
        shadow_digits_d[4*n +: 4] = dec[3:0];
        shadow_dots_d[n]          = sample[7];
      end
    end

    // A capture in the publish cycle lands after the clear and starts the next frame.
    seen_d        = ((seen_q == 4'hF) ? 4'h0 : seen_q) | (capture ? drv : 4'h0);
    frame_valid_d = (seen_q == 4'hF);
    digits_d      = frame_valid_d ? shadow_digits_q : digits_q;
    dots_d        = frame_valid_d ? shadow_dots_q : dots_q;

    if (capture)                    dead_cnt_d = '0;
    else if (dead_cnt_q == DEAD_MAX) dead_cnt_d = dead_cnt_q;
    else                            dead_cnt_d = dead_cnt_q + DW'(1);
    cap_d  = capture;
    // Dead drops one cycle after the capture that revives the display.
    dead_d = (dead_cnt_d == DEAD_MAX) || (dead_q && !cap_q);
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q         <= BUS_IDLE;
      sync2_q         <= BUS_IDLE;
      prev_q          <= '0;
      cnt_q           <= '0;
      shadow_digits_q <= '0;
      shadow_dots_q   <= '0;
      seen_q          <= '0;
      digits_q        <= '0;
      dots_q          <= '0;
      frame_valid_q   <= 1'b0;
      pattern_err_q   <= 1'b0;
      select_err_q    <= 1'b0;
      dead_cnt_q      <= '0;
      cap_q           <= 1'b0;
      dead_q          <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_dots_q   <= shadow_dots_d;
      seen_q          <= seen_d;
      digits_q        <= digits_d;
      dots_q          <= dots_d;
      frame_valid_q   <= frame_valid_d;
      pattern_err_q   <= pattern_err_d;
      select_err_q    <= select_err_d;
      dead_cnt_q      <= dead_cnt_d;
      cap_q           <= cap_d;
      dead_q          <= dead_d;
    end
  end

  assign Digits        = digits_q;
  assign Dots          = dots_q;
  assign Frame_Valid   = frame_valid_q;
  assign Pattern_Error = pattern_err_q;
  assign Select_Error  = select_err_q;
  assign Display_Dead  = dead_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: directed scenarios plus a randomized digit
// stream scored against a rule-level model of the display bus.
module tb_seven_segment_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 1000;
  localparam int SLOT   = 250;

  logic        clk;
  logic        rst_n;
  logic [3:0]  seg_drv;
  logic [7:0]  seg_bus;
  logic [15:0] digits;
  logic [3:0]  dots;
  logic        fv, pe, se, dead;

  seven_segment_decoder #(
    .STABLE_CYCLES(STABLE),
    .TIMEOUT(TMO),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .Clk_100M(clk),
    .Reset_n(rst_n),
    .SegmentDrivers(seg_drv),
    .SevenSegment(seg_bus),
    .Digits(digits),
    .Dots(dots),
    .Frame_Valid(fv),
    .Pattern_Error(pe),
    .Select_Error(se),
    .Display_Dead(dead)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] enc_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int total, bad;
  int fv_cnt, pe_cnt, se_cnt;
  int exp_fv, exp_pe, exp_se;
  int m_dig [4];
  logic [3:0] m_dot, m_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    logic [19:0] e;
    #1;
    if (rst_n === 1'b1) begin
      if (pe) pe_cnt++;
      if (se) se_cnt++;
      if (fv) begin
        fv_cnt++;
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("frame_content", {12'h0, dots, digits}, {12'h0, e});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int lookup(input logic [6:0] p);
    for (int v = 0; v < 10; v++) if (enc_tab[v] == p) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_seen = 4'h0;
    m_dot  = 4'h0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  // One held bus pattern (active-high view) lasting len cycles.
  task automatic model_step(input logic [3:0] d, input logic [7:0] s, input int len);
    int v;
    int pos;
    if (len < STABLE + 2) return;
    if ($countones(d) == 0 || s[6:0] == 7'h00) return;
    if ($countones(d) > 1) begin
      exp_se++;
      return;
    end
    v = lookup(s[6:0]);
    if (v < 0) begin
      exp_pe++;
      return;
    end
    pos = 0;
    for (int i = 0; i < 4; i++) if (d[i]) pos = i;
    m_dig[pos]  = v;
    m_dot[pos]  = s[7];
    m_seen[pos] = 1'b1;
    if (m_seen == 4'hF) begin
      exp_q.push_back({m_dot, 4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])});
      exp_fv++;
      m_seen = 4'h0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] d, input logic [7:0] s);
    seg_drv = ~d;
    seg_bus = ~s;
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    drive(d, s);
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int pos, input int v, input bit dp, input int n);
    hold(4'(1 << pos), {dp, enc_tab[v]}, n);
  endtask

  task automatic idle(input int n);
    hold(4'h0, 8'h00, n);
  endtask

  task automatic push_frame(input logic [3:0] dt, input logic [15:0] dg);
    exp_q.push_back({dt, dg});
    exp_fv++;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive(4'h0, 8'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_digits", {16'h0, digits}, 32'h0);
    check("rst_dots", {28'h0, dots}, 32'h0);
    check("rst_frame_valid", {31'h0, fv}, 32'h0);
    check("rst_pattern_err", {31'h0, pe}, 32'h0);
    check("rst_select_err", {31'h0, se}, 32'h0);
    check("rst_dead", {31'h0, dead}, 32'h0);
    rst_n = 1'b1;

    // Dead display: idle bus since reset release.
    repeat (TMO - 1) @(negedge clk);
    check("dead_before_timeout", {31'h0, dead}, 32'h0);
    @(negedge clk);
    check("dead_at_timeout", {31'h0, dead}, 32'h1);

    // Basic frame 12:34; the first digit also revives the display.
    push_frame(4'h0, 16'h1234);
    show(0, 4, 1'b0, 6);
    check("dead_held_at_capture", {31'h0, dead}, 32'h1);
    @(negedge clk);
    check("dead_clear_after_capture", {31'h0, dead}, 32'h0);
    repeat (SLOT - 7) @(negedge clk);
    show(1, 3, 1'b0, SLOT);
    show(2, 2, 1'b0, SLOT);
    show(3, 1, 1'b0, 6);
    check("fv_not_early", {31'h0, fv}, 32'h0);
    @(negedge clk);
    check("fv_latency", {31'h0, fv}, 32'h1);
    check("fv_digits", {16'h0, digits}, 32'h1234);
    @(negedge clk);
    check("fv_single_cycle", {31'h0, fv}, 32'h0);
    idle(20);
    check("basic_frames", fv_cnt, exp_fv);
    check("basic_pattern_errs", pe_cnt, exp_pe);
    check("basic_select_errs", se_cnt, exp_se);

    // PWM dimming: short lit window, long blanked remainder per slot.
    push_frame(4'h0, 16'h1234);
    for (int p = 0; p < 4; p++) begin
      show(p, 4 - p, 1'b0, 10);
      hold(4'(1 << p), 8'h00, 90);
    end
    idle(20);
    check("pwm_frames", fv_cnt, exp_fv);
    check("pwm_errs", pe_cnt + se_cnt, exp_pe + exp_se);

    // A 3-cycle pulse must not count as d0.
    show(0, 8, 1'b0, 3);
    hold(4'b0001, 8'h00, 20);
    show(1, 3, 1'b0, 20);
    show(2, 2, 1'b0, 20);
    show(3, 1, 1'b0, 20);
    idle(20);
    check("glitch_rejected", fv_cnt, exp_fv);
    push_frame(4'h0, 16'h1237);
    show(0, 7, 1'b0, 20);
    idle(20);
    check("glitch_then_frame", fv_cnt, exp_fv);

    // Bad pattern on d2, then bad select.
    show(0, 5, 1'b0, 20);
    show(1, 6, 1'b0, 20);
    hold(4'b0100, 8'h49, 20);
    exp_pe++;
    show(3, 0, 1'b0, 20);
    idle(20);
    check("bad_pattern_pulse", pe_cnt, exp_pe);
    check("bad_pattern_no_frame", fv_cnt, exp_fv);
    push_frame(4'h0, 16'h0765);
    show(2, 7, 1'b0, 20);
    idle(20);
    check("bad_pattern_recovered", fv_cnt, exp_fv);
    hold(4'b0011, {1'b0, enc_tab[1]}, 20);
    exp_se++;
    idle(20);
    check("bad_select_pulse", se_cnt, exp_se);
    check("bad_select_no_frame", fv_cnt, exp_fv);

    // Overwrite of d0 and dp on d2.
    push_frame(4'b0100, 16'h8329);
    show(0, 5, 1'b0, 20);
    show(1, 2, 1'b0, 20);
    show(2, 3, 1'b1, 20);
    show(0, 9, 1'b0, 20);
    show(3, 8, 1'b0, 20);
    idle(20);
    check("overwrite_frames", fv_cnt, exp_fv);

    // Reset mid-frame discards the partial frame.
    show(0, 1, 1'b0, 20);
    show(1, 2, 1'b0, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_digits", {16'h0, digits}, 32'h0);
    check("midrst_dots", {28'h0, dots}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    show(2, 3, 1'b0, 20);
    show(3, 4, 1'b0, 20);
    idle(30);
    check("midrst_no_frame", fv_cnt, exp_fv);

    // Randomized stream against the model.
    pulse_reset();
    model_reset();
    begin : rand_blk
      logic [3:0]  d;
      logic [7:0]  s;
      logic [6:0]  p;
      logic [11:0] prev_raw;
      int len, kind, pos;
      prev_raw = 12'h000;
      for (int k = 0; k < 120; k++) begin
        do begin
          kind = $urandom_range(0, 9);
          if (kind <= 5) begin
            pos = $urandom_range(0, 3);
            d = 4'(1 << pos);
            s = {1'($urandom_range(0, 1)), enc_tab[$urandom_range(0, 9)]};
          end else if (kind == 6) begin
            d = 4'($urandom_range(1, 15));
            s = {1'($urandom_range(0, 1)), 7'h00};
          end else if (kind == 7) begin
            d = 4'h0;
            s = 8'($urandom_range(0, 255));
          end else if (kind == 8) begin
            pos = $urandom_range(0, 3);
            d = 4'(1 << pos);
            do p = 7'($urandom_range(1, 127)); while (lookup(p) >= 0);
            s = {1'($urandom_range(0, 1)), p};
          end else begin
            do d = 4'($urandom_range(3, 15)); while ($countones(d) < 2);
            s = 8'($urandom_range(1, 255));
            if (s[6:0] == 7'h00) s[0] = 1'b1;
          end
        end while ({d, s} == prev_raw);
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 25);
        model_step(d, s, len);
        hold(d, s, len);
        prev_raw = {d, s};
      end
      idle(30);
    end
    check("rand_frames", fv_cnt, exp_fv);
    check("rand_queue_drained", exp_q.size(), 0);
    check("rand_pattern_errs", pe_cnt, exp_pe);
    check("rand_select_errs", se_cnt, exp_se);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
